collision_detector: RTL and testbench
=====================================

COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum stored body segments.
REQ-002 SHALL have parameter X_MAX, default 11: largest legal head X; larger X is a wall hit.
REQ-003 SHALL have parameter Y_MAX, default 7: largest legal head Y; larger Y is a wall hit.
REQ-004 SHALL have parameters START_X / START_Y, default 4 / 4: initial body segment.
REQ-005 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port moveStrobe, input, 1: one-cycle pulse; the new head position is valid.
REQ-008 SHALL have port headX / headY, input, 4 each: the new head coordinate.
REQ-009 SHALL have port appleX / appleY, input, 4 each: the current apple coordinate.
REQ-010 SHALL have port isGameComplete, input, 1: high means the game has ended; moves are ignored.
REQ-011 SHALL have port goodColl, output, 1: one-cycle pulse; the head ate the apple.
REQ-012 SHALL have port badColl, output, 1: one-cycle pulse; wall or self hit.
REQ-013 SHALL have port busy, output, 1: high while a move is being evaluated.
REQ-014 SHALL have port snakeLen, output, 5: the current stored segment count.
REQ-015 SHALL have port dead, output, 1: sticky flag, set by badColl.

Function
REQ-016 SHALL implement an FSM with states IDLE, SCAN and RESOLVE; busy = (state != IDLE).
REQ-017 In IDLE, moveStrobe with isGameComplete=0 and dead=0 SHALL latch the head and apple coordinates, clear the hit flag, set idx=0 and enter SCAN.
- Otherwise moveStrobe SHALL be ignored.
REQ-018 moveStrobe SHALL be ignored while busy; there is no queuing.
REQ-019 SCAN SHALL compare the latched head with body[idx], one segment per cycle.
- Any match SHALL set the hit flag.
- After idx = snakeLen-1 the FSM SHALL enter RESOLVE.
- SCAN therefore lasts exactly snakeLen cycles.
REQ-020 RESOLVE SHALL last one cycle, then the FSM SHALL return to IDLE.
REQ-021 Wall hit SHALL be defined as headX > X_MAX or headY > Y_MAX.
REQ-022 Bad = wall hit OR hit flag.
REQ-023 Good = not Bad AND head == apple.
REQ-024 If both conditions hold, Bad SHALL win and goodColl SHALL stay low.
REQ-025 goodColl and badColl SHALL be registered and high for exactly the cycle after RESOLVE.
- For a strobe in cycle N, the pulse falls in cycle N+L+2, where L = snakeLen at the strobe.
REQ-026 On a non-Bad resolve, the body SHALL shift: body[i+1] <= body[i], body[0] <= head.
REQ-027 On Good, snakeLen SHALL increment, saturating at MAX_LEN.
- At saturation the oldest segment SHALL be dropped and goodColl SHALL still pulse.
REQ-028 On Bad, the body and snakeLen SHALL be unchanged and dead SHALL be set.
REQ-029 dead SHALL clear only on reset.
REQ-030 Body entries at index >= snakeLen SHALL never be compared.

Reset
REQ-031 While reset is high, the block SHALL immediately hold:
- state = IDLE
- goodColl = badColl = busy = dead = 0
- snakeLen = 1
- body[0] = (START_X, START_Y)
- all other entries = (0,0)
REQ-032 Reset asserted mid-SCAN or mid-RESOLVE SHALL abort the move with no pulse and no body update.

Configuration
REQ-033 Macro SELF_COLLISION_EN SHALL control the self-collision check.
- Defined: SCAN behaves as specified.
- Undefined: IDLE goes straight to RESOLVE, the hit flag is always 0 and only wall hits are Bad.
- Undefined: pulse latency is N+2.

Structure
REQ-034 Shared package snake_pkg SHALL hold the coordinate typedef (struct of two 4-bit fields), the FSM state enum and the MAX_LEN default.
REQ-035 The segment array plus shift logic SHALL be a sub-module, snake_body_buf.
- It has a shift/insert port and an indexed read port.

Verification
REQ-036 The bench SHALL cover the following scenarios:
- Reset, then strobe head=(5,4), apple=(9,9) -> SCAN 1 cycle; no pulse; snakeLen=1; body[0]=(5,4).
- Strobe head=(6,4), apple=(6,4), snakeLen=1, strobe in cycle N -> goodColl high only in cycle N+3; snakeLen=2.
- Strobe head=(12,0) with X_MAX=11 -> badColl pulse; dead=1; a further strobe gives no pulse and busy stays 0.
- Grow to snakeLen=4, then strobe a head equal to body[3] while apple is at the same cell -> badColl only; goodColl stays 0.
- Second strobe 1 cycle after the first while busy -> ignored; exactly one pulse total.
- Reset asserted mid-SCAN with snakeLen=5 -> no pulse; snakeLen=1.
- SELF_COLLISION_EN undefined: head equal to a body segment -> no badColl; latency 2.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake collision logic: the board coordinate, the move-evaluation
// FSM states and the default body depth.
package snake_pkg;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESOLVE
  } state_t;

  localparam int unsigned MAX_LEN_DEFAULT = 16;

endpackage

// File: rtl/snake_body_buf.sv
// Snake body segment store: one-step shift/insert at the head end, plus a
// combinational indexed read port. The oldest entry falls off the far end on every shift.
module snake_body_buf
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT,
  parameter int unsigned START_X = 4,
  parameter int unsigned START_Y = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       shift,
  input  logic [7:0]                 din,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [7:0]                 rd_data
);

  coord_t body [MAX_LEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      body[0] <= '{x: 4'(START_X), y: 4'(START_Y)};
      for (int unsigned i = 1; i < MAX_LEN; i++) begin
        body[i] <= '0;
      end
    end else if (shift) begin
      for (int unsigned i = MAX_LEN - 1; i > 0; i--) begin
        body[i] <= body[i-1];
      end
      body[0] <= coord_t'(din);
    end
  end

  assign rd_data = body[rd_idx];

endmodule

// File: rtl/collision_detector.sv
// Evaluates each snake move for wall, self and apple collisions and maintains the body.
// Macro SELF_COLLISION_EN enables the per-segment self-collision scan.
module collision_detector
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT,
  parameter int unsigned X_MAX   = 11,
  parameter int unsigned Y_MAX   = 7,
  parameter int unsigned START_X = 4,
  parameter int unsigned START_Y = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       moveStrobe,
  input  logic [3:0] headX,
  input  logic [3:0] headY,
  input  logic [3:0] appleX,
  input  logic [3:0] appleY,
  input  logic       isGameComplete,
  output logic       goodColl,
  output logic       badColl,
  output logic       busy,
  output logic [4:0] snakeLen,
  output logic       dead
);

  localparam int unsigned IW = $clog2(MAX_LEN);

  state_t          state;
  coord_t          head_q;
  coord_t          apple_q;
  coord_t          seg;
  logic            hit;
  logic [IW-1:0]   idx;
  logic            wall;
  logic            is_bad;
  logic            is_good;
  logic            do_shift;
  logic [7:0]      rd_data;

  assign seg      = coord_t'(rd_data);
  assign wall     = ({28'd0, head_q.x} > X_MAX) || ({28'd0, head_q.y} > Y_MAX);
  assign is_bad   = wall || hit;
  assign is_good  = !is_bad && (head_q == apple_q);
  assign do_shift = (state == RESOLVE) && !is_bad;
  assign busy     = (state != IDLE);

  snake_body_buf #(
    .MAX_LEN(MAX_LEN),
    .START_X(START_X),
    .START_Y(START_Y)
  ) u_body (
    .clk    (clk),
    .reset  (reset),
    .shift  (do_shift),
    .din    (head_q),
    .rd_idx (idx),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      head_q   <= '0;
      apple_q  <= '0;
      hit      <= 1'b0;
      idx      <= '0;
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      dead     <= 1'b0;
      snakeLen <= 5'd1;
    end else begin
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      case (state)
        IDLE: begin
          if (moveStrobe && !isGameComplete && !dead) begin
            head_q  <= '{x: headX, y: headY};
            apple_q <= '{x: appleX, y: appleY};
            hit     <= 1'b0;
            idx     <= '0;
`ifdef SELF_COLLISION_EN
            state   <= SCAN;
`else
            state   <= RESOLVE;
`endif
          end
        end
        SCAN: begin
          if (seg == head_q) hit <= 1'b1;
          if (5'(idx) == snakeLen - 5'd1) state <= RESOLVE;
          else idx <= idx + 1'b1;
        end
        RESOLVE: begin
          state <= IDLE;
          if (is_bad) begin
            badColl <= 1'b1;
            dead    <= 1'b1;
          end else if (is_good) begin
            goodColl <= 1'b1;
            if (snakeLen < 5'(MAX_LEN)) snakeLen <= snakeLen + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector; expected latencies follow SELF_COLLISION_EN.
module tb_collision_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       moveStrobe;
  logic [3:0] headX, headY, appleX, appleY;
  logic       isGameComplete;
  logic       goodColl, badColl, busy, dead;
  logic [4:0] snakeLen;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  collision_detector #(
    .MAX_LEN(16),
    .X_MAX  (11),
    .Y_MAX  (7),
    .START_X(4),
    .START_Y(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .moveStrobe    (moveStrobe),
    .headX         (headX),
    .headY         (headY),
    .appleX        (appleX),
    .appleY        (appleY),
    .isGameComplete(isGameComplete),
    .goodColl      (goodColl),
    .badColl       (badColl),
    .busy          (busy),
    .snakeLen      (snakeLen),
    .dead          (dead)
  );

  function automatic int exp_lat(input int len);
`ifdef SELF_COLLISION_EN
    return len + 2;
`else
    return 2;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Strobe in cycle N; sample k negedges later, i.e. the outputs of cycle N+k.
  task automatic do_move(input logic [3:0] hx, hy, ax, ay, input bit dbl,
                         output int good_k, output int bad_k,
                         output int n_good, output int n_bad, output logic busy1);
    @(negedge clk);
    headX = hx; headY = hy; appleX = ax; appleY = ay;
    moveStrobe = 1'b1;
    good_k = 0; bad_k = 0; n_good = 0; n_bad = 0; busy1 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (goodColl === 1'b1) begin n_good++; if (good_k == 0) good_k = k; end
      if (badColl === 1'b1) begin n_bad++; if (bad_k == 0) bad_k = k; end
      moveStrobe = dbl && (k == 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++; if (snakeLen !== 5'd1) begin n_fail++; $display("FAIL reset_len got=%0d want=1", snakeLen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (dead !== 1'b0) begin n_fail++; $display("FAIL reset_dead got=%b want=0", dead); end
    n_checks++; if ({goodColl, badColl} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got=%b want=00", {goodColl, badColl}); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_first_move();
    int gk, bk, ng, nb; logic b1;
    do_move(4'd5, 4'd4, 4'd9, 4'd9, 1'b0, gk, bk, ng, nb, b1);
    n_checks++; if (ng + nb != 0) begin n_fail++; $display("FAIL first_pulses got=%0d want=0", ng + nb); end
    n_checks++; if (snakeLen !== 5'd1) begin n_fail++; $display("FAIL first_len got=%0d want=1", snakeLen); end
    n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL first_busy got=%b want=1", b1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_idle got=%b want=0", busy); end
  endtask

  task automatic test_grow_and_self_hit();
    int gk, bk, ng, nb; logic b1;
    do_move(4'd6, 4'd4, 4'd6, 4'd4, 1'b0, gk, bk, ng, nb, b1);
    n_checks++; if (gk != exp_lat(1) || ng != 1 || nb != 0) begin n_fail++; $display("FAIL good1 got=k%0d n%0d b%0d want=k%0d n1 b0", gk, ng, nb, exp_lat(1)); end
    n_checks++; if (snakeLen !== 5'd2) begin n_fail++; $display("FAIL good1_len got=%0d want=2", snakeLen); end
    do_move(4'd7, 4'd4, 4'd7, 4'd4, 1'b0, gk, bk, ng, nb, b1);
    n_checks++; if (gk != exp_lat(2)) begin n_fail++; $display("FAIL good2_lat got=%0d want=%0d", gk, exp_lat(2)); end
    do_move(4'd7, 4'd5, 4'd7, 4'd5, 1'b0, gk, bk, ng, nb, b1);
    n_checks++; if (gk != exp_lat(3)) begin n_fail++; $display("FAIL good3_lat got=%0d want=%0d", gk, exp_lat(3)); end
    n_checks++; if (snakeLen !== 5'd4) begin n_fail++; $display("FAIL grow_len got=%0d want=4", snakeLen); end
    // body is now (7,5),(7,4),(6,4),(5,4); head and apple on body[3]
    do_move(4'd5, 4'd4, 4'd5, 4'd4, 1'b0, gk, bk, ng, nb, b1);
`ifdef SELF_COLLISION_EN
    n_checks++; if (bk != exp_lat(4) || nb != 1 || ng != 0) begin n_fail++; $display("FAIL self_hit got=k%0d b%0d g%0d want=k%0d b1 g0", bk, nb, ng, exp_lat(4)); end
    n_checks++; if (dead !== 1'b1 || snakeLen !== 5'd4) begin n_fail++; $display("FAIL self_state got=dead%b len%0d want=dead1 len4", dead, snakeLen); end
`else
    n_checks++; if (gk != 2 || ng != 1 || nb != 0) begin n_fail++; $display("FAIL noself got=k%0d g%0d b%0d want=k2 g1 b0", gk, ng, nb); end
    n_checks++; if (dead !== 1'b0 || snakeLen !== 5'd5) begin n_fail++; $display("FAIL noself_state got=dead%b len%0d want=dead0 len5", dead, snakeLen); end
`endif
  endtask

  task automatic test_wall();
    int gk, bk, ng, nb; logic b1;
    do_reset();
    do_move(4'd11, 4'd7, 4'd0, 4'd0, 1'b0, gk, bk, ng, nb, b1);
    n_checks++; if (nb != 0 || dead !== 1'b0) begin n_fail++; $display("FAIL corner got=b%0d dead%b want=b0 dead0", nb, dead); end
    do_move(4'd12, 4'd0, 4'd0, 4'd0, 1'b0, gk, bk, ng, nb, b1);
    n_checks++; if (bk != exp_lat(1) || nb != 1) begin n_fail++; $display("FAIL wall_x got=k%0d n%0d want=k%0d n1", bk, nb, exp_lat(1)); end
    n_checks++; if (dead !== 1'b1 || snakeLen !== 5'd1) begin n_fail++; $display("FAIL wall_state got=dead%b len%0d want=dead1 len1", dead, snakeLen); end
    do_move(4'd3, 4'd3, 4'd3, 4'd3, 1'b0, gk, bk, ng, nb, b1);
    n_checks++; if (ng + nb != 0 || b1 !== 1'b0) begin n_fail++; $display("FAIL dead_ignore got=p%0d busy%b want=p0 busy0", ng + nb, b1); end
    do_reset();
    do_move(4'd3, 4'd8, 4'd3, 4'd8, 1'b0, gk, bk, ng, nb, b1);
    n_checks++; if (nb != 1 || ng != 0) begin n_fail++; $display("FAIL wall_y got=b%0d g%0d want=b1 g0", nb, ng); end
  endtask

  task automatic test_game_complete();
    int gk, bk, ng, nb; logic b1;
    do_reset();
    isGameComplete = 1'b1;
    do_move(4'd5, 4'd4, 4'd5, 4'd4, 1'b0, gk, bk, ng, nb, b1);
    isGameComplete = 1'b0;
    n_checks++; if (ng + nb != 0 || b1 !== 1'b0 || snakeLen !== 5'd1) begin n_fail++; $display("FAIL complete got=p%0d busy%b len%0d want=p0 busy0 len1", ng + nb, b1, snakeLen); end
  endtask

  task automatic test_back_to_back();
    int gk, bk, ng, nb; logic b1;
    do_reset();
    do_move(4'd6, 4'd4, 4'd6, 4'd4, 1'b1, gk, bk, ng, nb, b1);
    n_checks++; if (ng != 1 || nb != 0 || gk != exp_lat(1)) begin n_fail++; $display("FAIL b2b got=g%0d b%0d k%0d want=g1 b0 k%0d", ng, nb, gk, exp_lat(1)); end
    n_checks++; if (snakeLen !== 5'd2) begin n_fail++; $display("FAIL b2b_len got=%0d want=2", snakeLen); end
  endtask

  task automatic test_reset_mid_scan();
    int gk, bk, ng, nb, abort_k; logic b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_move(4'(5 + i), 4'd4, 4'(5 + i), 4'd4, 1'b0, gk, bk, ng, nb, b1);
    end
    n_checks++; if (snakeLen !== 5'd5) begin n_fail++; $display("FAIL pre_abort_len got=%0d want=5", snakeLen); end
`ifdef SELF_COLLISION_EN
    abort_k = 3;
`else
    abort_k = 1;
`endif
    @(negedge clk);
    headX = 4'd9; headY = 4'd4; appleX = 4'd9; appleY = 4'd4;
    moveStrobe = 1'b1;
    ng = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      moveStrobe = 1'b0;
      if (goodColl === 1'b1 || badColl === 1'b1) ng++;
      reset = (k == abort_k);
    end
    n_checks++; if (ng != 0) begin n_fail++; $display("FAIL abort_pulse got=%0d want=0", ng); end
    n_checks++; if (snakeLen !== 5'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_state got=len%0d busy%b want=len1 busy0", snakeLen, busy); end
  endtask

  initial begin
    reset = 1'b0; moveStrobe = 1'b0; isGameComplete = 1'b0;
    headX = '0; headY = '0; appleX = '0; appleY = '0;
    test_reset();
    test_first_move();
    test_grow_and_self_hit();
    test_wall();
    test_game_complete();
    test_back_to_back();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
